// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   if_req_i/if_addr_i                 fetch request (read-only)
//   if_gnt_o/if_rvalid_o/if_rdata_o    fetch grant and response
//   dm_req_i/addr/we/be/wdata          data request
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o    data grant and response
//   mem_req_o/addr/we/be/wdata         shared memory request, held from latched registers
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i memory accept and response
module mem_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_req_i,
    input  logic [WORD_SIZE-1:0]   if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [WORD_SIZE-1:0]   if_rdata_o,
    input  logic                   dm_req_i,
    input  logic [WORD_SIZE-1:0]   dm_addr_i,
    input  logic                   dm_we_i,
    input  logic [WORD_SIZE/8-1:0] dm_be_i,
    input  logic [WORD_SIZE-1:0]   dm_wdata_i,
    output logic                   dm_gnt_o,
    output logic                   dm_rvalid_o,
    output logic [WORD_SIZE-1:0]   dm_rdata_o,
    output logic                   mem_req_o,
    output logic [WORD_SIZE-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]   mem_wdata_o,
    output logic                   mem_we_o,
    output logic [WORD_SIZE/8-1:0] mem_be_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state;
    logic last_dm, owner_dm, pick_dm, grant, resp;
    // DM wins when alone, or on a tie when fetch was served last
    assign pick_dm     = dm_req_i & (~if_req_i | ~last_dm);
    assign grant       = ~rst_i & (state == IDLE) & (if_req_i | dm_req_i);
    assign if_gnt_o    = grant & ~pick_dm;
    assign dm_gnt_o    = grant & pick_dm;
    assign resp        = ~rst_i & (state == WAIT) & mem_rvalid_i;
    assign if_rvalid_o = resp & ~owner_dm;
    assign dm_rvalid_o = resp & owner_dm;
    assign if_rdata_o  = rst_i ? '0 : mem_rdata_i;
    assign dm_rdata_o  = rst_i ? '0 : mem_rdata_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_dm     <= 1'b1;
            owner_dm    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state       <= ISSUE;
                    mem_req_o   <= 1'b1;
                    owner_dm    <= pick_dm;
                    last_dm     <= pick_dm;
                    mem_addr_o  <= pick_dm ? dm_addr_i : if_addr_i;
                    mem_wdata_o <= pick_dm ? dm_wdata_i : '0;
                    mem_we_o    <= pick_dm & dm_we_i;
                    mem_be_o    <= pick_dm ? dm_be_i : '1;
                end
                ISSUE: if (mem_gnt_i) begin
                    state     <= WAIT;
                    mem_req_o <= 1'b0;
                end
                WAIT: if (mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, meaning address/data width in bits (multiple of 8).
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port if_req_i  in  1  instruction-fetch request (read-only requester).
REQ-005 SHALL have port if_addr_i  in  WORD_SIZE  fetch address.
REQ-006 SHALL have port if_gnt_o  out  1  fetch request accepted.
REQ-007 SHALL have port if_rvalid_o  out  1  fetch response valid.
REQ-008 SHALL have port if_rdata_o  out  WORD_SIZE  fetch response data.
REQ-009 SHALL have port dm_req_i  in  1  data-memory request.
REQ-010 SHALL have port dm_addr_i  in  WORD_SIZE  data address.
REQ-011 SHALL have port dm_we_i  in  1  1 = store, 0 = load.
REQ-012 SHALL have port dm_be_i  in  WORD_SIZE/8  store byte enables.
REQ-013 SHALL have port dm_wdata_i  in  WORD_SIZE  store data.
REQ-014 SHALL have port dm_gnt_o  out  1  data request accepted.
REQ-015 SHALL have port dm_rvalid_o  out  1  data response valid (load data or store ack).
REQ-016 SHALL have port dm_rdata_o  out  WORD_SIZE  load data.
REQ-017 SHALL have port mem_req_o  out  1  request to shared memory.
REQ-018 SHALL have ports mem_addr_o / mem_wdata_o  out  WORD_SIZE each  memory address / store data.
REQ-019 SHALL have ports mem_we_o  out  1 and mem_be_o  out  WORD_SIZE/8  memory write enable / byte enables.
REQ-020 SHALL have port mem_gnt_i  in  1  memory accepted mem_req_o.
REQ-021 SHALL have port mem_rvalid_i  in  1  memory response (reads and writes).
REQ-022 SHALL have port mem_rdata_i  in  WORD_SIZE  memory read data.

Function
REQ-023 SHALL implement FSM IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-024 IDLE: if any req_i high, SHALL select one owner, assert its gnt_o combinationally that cycle, latch addr/we/be/wdata (IF: we=0, be=all-ones, wdata=0) and owner, go ISSUE; else stay IDLE.
REQ-025 Arbitration SHALL be round-robin: single requester wins; both requesting -> the one not granted last; last_owner updates on each grant.
REQ-026 gnt_o SHALL be asserted only in IDLE, never to both requesters, never without its req_i.
REQ-027 ISSUE: mem_req_o=1 driven from latched registers, held stable until mem_gnt_i; on mem_gnt_i go WAIT.
REQ-028 WAIT: on mem_rvalid_i, owner's rvalid_o=1 that cycle, rdata_o=mem_rdata_i, go IDLE; stores also complete on mem_rvalid_i.
REQ-029 Non-owner rvalid_o SHALL stay 0; mem_rvalid_i in IDLE or ISSUE SHALL be ignored.
REQ-030 mem_req_o SHALL be 0 outside ISSUE; mem_addr_o/we/be/wdata hold last latched values.
REQ-031 Min latency: grant cycle N, mem_req_o N+1, with mem_gnt_i at N+1 and mem_rvalid_i at N+2 -> rvalid_o at N+2; next grant earliest N+3.
REQ-032 A requester dropping req_i before grant SHALL cause no transaction; inputs after grant are don't-care.
REQ-033 if_rdata_o/dm_rdata_o SHALL both equal mem_rdata_i at all times (qualified only by rvalid_o).

Reset
REQ-034 rst_i high at a clock edge SHALL force IDLE, last_owner=DM (IF wins first tie), latched regs=0; all outputs 0 while in reset.
REQ-035 Reset mid-transaction SHALL abandon it silently; late mem_rvalid_i SHALL produce no rvalid_o.

Verification
REQ-036 Reset then if_req_i=1, addr 0x100, mem_gnt_i same cycle as mem_req_o, rvalid next cycle with 0xDEADBEEF -> if_gnt_o cycle 0, mem_req_o cycle 1 addr 0x100 we=0, if_rvalid_o cycle 2 data 0xDEADBEEF.
REQ-037 Both requesting continuously, 4 transactions -> grant order IF, DM, IF, DM; no double grant.
REQ-038 DM store addr 0x40, be=0x3, wdata 0x1234, mem_gnt_i delayed 3 cycles -> mem_req_o high 4 cycles, outputs stable, dm_rvalid_o on ack, if_rvalid_o stays 0.
REQ-039 mem_rvalid_i pulsed while IDLE and while ISSUE -> no rvalid_o, state unchanged.
REQ-040 rst_i asserted in WAIT, then mem_rvalid_i -> no rvalid_o; next if_req_i served normally.
